// File: rtl/booth_cycle_sequencer.sv
// -----------------------------------------------------------------------------
// booth_cycle_sequencer
//
// Step sequencer for the Booth multiplier control path. It counts Booth
// iterations from 0 up to a programmable terminal value and tells the
// multiplier FSM when the last iteration has been issued. It uses a
// start/busy/done handshake and produces a registered terminal-compare flag.
//
// Parameters
//   Width      counter and terminal-value width in bits
//   TermReset  terminal register value after reset (14 = legacy 15 steps)
//
// Ports
//   clk          clock; all state updates on the rising edge
//   reset        synchronous, active-high reset; overrides every other input
//   start        begin a sequence (sampled only in IDLE)
//   load_term    write term_in into the terminal register (only in IDLE)
//   term_in      new terminal value
//   en           step enable while running
//   count        current step index
//   busy         high while the sequence is running
//   comp         count matched the terminal value on the previous RUN cycle
//   done         one-cycle completion pulse
//   auto_reload  wrap to 0 at the terminal instead of finishing
//                (port exists only when BCS_AUTO_RELOAD_EN is defined)
//
// Build option
//   BCS_AUTO_RELOAD_EN  adds the auto_reload port. Without it, the logic is
//                       the same as with auto_reload tied low.
// -----------------------------------------------------------------------------
module booth_cycle_sequencer #(
   parameter int          Width     = 5,
   parameter int unsigned TermReset = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             load_term,
   input  logic [Width-1:0] term_in,
   input  logic             en,
   output logic [Width-1:0] count,
   output logic             busy,
   output logic             comp,
   output logic             done
`ifdef BCS_AUTO_RELOAD_EN
   ,
   input  logic             auto_reload
`endif
);

   localparam logic [Width-1:0] TermInit = Width'(TermReset);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [Width-1:0] term;
   logic [Width-1:0] count_next;
   logic             at_term;
   logic             hit;
   logic             reload;

`ifdef BCS_AUTO_RELOAD_EN
   assign reload = auto_reload;
`else
   assign reload = 1'b0;
`endif

   assign at_term = (count == term);
   // Enabled step taken while the count sits on the terminal value.
   assign hit     = (state == S_RUN) && en && at_term;

   // State register
   always_ff @(posedge clk) begin
      // NOTE: all clocked state uses non-blocking assignments. Then every
      // flop samples values from before the edge, whatever the process order.
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: the default first assignment covers every path through the
      // case. Without it, synthesis would infer a latch.
      state_next = state;
      case (state)
         S_IDLE:  if (start) state_next = S_RUN;
         S_RUN:   if (hit && !reload) state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state == S_RUN);
   end

   // Step counter: cleared outside RUN. While running it advances on en,
   // holds at the terminal value, or wraps to 0 when auto-reload is on.
   always_comb begin
      count_next = count;
      case (state)
         S_RUN: begin
            if (en) begin
               if (!at_term) begin
                  count_next = count + Width'(1);
               end else if (reload) begin
                  count_next = '0;
               end
            end
         end
         default: count_next = '0;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      // NOTE: the terminal register is reset like a control flop, not left
      // as uninitialised storage. A reset mid-sequence must restore the
      // legacy step count.
      if (reset) begin
         count <= '0;
         term  <= TermInit;
         comp  <= 1'b0;
         done  <= 1'b0;
      end else begin
         count <= count_next;
         // Writing at the same edge that leaves IDLE makes a start paired
         // with load_term run with the new terminal value.
         if ((state == S_IDLE) && load_term) begin
            term <= term_in;
         end
         comp <= (state == S_RUN) && at_term;
         // A registered pulse works for both the DONE entry and an auto-reload
         // wrap, which stays in RUN.
         done <= hit;
      end
   end

endmodule
